// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, runs the imem handshake, holds one
// instruction for the decoder with a 1-entry skid buffer, and accepts redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instr_fetch_unit_if.master        imem,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      if_valid,
  output logic [31:0]               if_instr,
  output logic [31:0]               if_pc,
  output logic [31:0]               if_pc4,
  output logic [5:0]                operation_front,
  output logic [4:0]                instruction25_21,
  output logic [4:0]                instruction20_16,
  output logic [5:0]                operation_code
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

  state_t      state, next_state;
  logic [31:0] pc, addr;
  logic [31:0] skid_instr, skid_pc;
  logic [31:0] target;
  logic        req;
  logic        take_word, to_skid, unskid, addr_from_pc, addr_from_target;

  assign target = redirect_pc & ~32'h3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = FETCH;
      FETCH: begin
        if (redirect_valid)
          next_state = imem.imem_ready ? FETCH : FLUSH;
        else if (imem.imem_ready && if_valid && stall)
          next_state = HOLD;
      end
      HOLD:  if (redirect_valid || !stall) next_state = FETCH;
      FLUSH: if (!redirect_valid && imem.imem_ready) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req              = 1'b0;
    take_word        = 1'b0;
    to_skid          = 1'b0;
    unskid           = 1'b0;
    addr_from_pc     = 1'b0;
    addr_from_target = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) addr_from_target = 1'b1;
        else                addr_from_pc     = 1'b1;
      end
      FETCH: begin
        req = 1'b1;
        if (redirect_valid) begin
          // Without a response the old request stays outstanding, so the
          // address must not move until FLUSH sees it answered.
          addr_from_target = imem.imem_ready;
        end else if (imem.imem_ready) begin
          if (!if_valid || !stall) take_word = 1'b1;
          else                     to_skid   = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          addr_from_target = 1'b1;
        end else if (!stall) begin
          unskid       = 1'b1;
          addr_from_pc = 1'b1;
        end
      end
      FLUSH: begin
        req = 1'b1;
        if (!redirect_valid && imem.imem_ready) addr_from_pc = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the skid registers are reset along with the datapath; they are few
  // flops and a defined value keeps the outputs X-free after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      addr       <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (redirect_valid)           pc <= target;
      else if (take_word || to_skid) pc <= addr + PC_STEP;

      if (addr_from_target)  addr <= target;
      else if (addr_from_pc) addr <= pc;
      else if (take_word)    addr <= addr + PC_STEP;

      if (redirect_valid)          if_valid <= 1'b0;
      else if (take_word || unskid) if_valid <= 1'b1;
      else if (if_valid && !stall)  if_valid <= 1'b0;

      if (take_word) begin
        if_instr <= imem.imem_rdata;
        if_pc    <= addr;
      end else if (unskid) begin
        if_instr <= skid_instr;
        if_pc    <= skid_pc;
      end

      if (to_skid) begin
        skid_instr <= imem.imem_rdata;
        skid_pc    <= addr;
      end
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  assign if_pc4           = if_pc + 32'd4;
  assign operation_front  = if_instr[31:26];
  assign instruction25_21 = if_instr[25:21];
  assign instruction20_16 = if_instr[20:16];
  assign operation_code   = if_instr[5:0];

endmodule
